// File: rtl/stat_counter_bank.sv
// -----------------------------------------------------------------------------
// stat_counter_bank
//
// Bank of NUM_CH independent event counters with a sticky per-channel
// overflow flag and a fixed-latency memory-mapped read port.
//
// Optional feature macro: STAT_CLEAR_ON_READ_EN
//   defined   : a counter read clears that counter and its overflow flag
//               after returning the old value; a bitmap read clears all
//               overflow flags except those set in the same cycle.
//   undefined : reads are non-destructive.
//
// Parameters:
//   NUM_CH   number of counter channels (1..CNT_W)
//   CNT_W    counter width in bits (2..64)
//   ADDR_W   read address width, 2^ADDR_W > NUM_CH
//   SATURATE 1 = hold at all-ones on overflow, 0 = wrap to zero
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, clears all state
//   stat_valid  per-channel event strobe, bit i = one event on channel i
//   stat_reset  synchronous bank clear (counters and overflow flags)
//   rd_req      read request, accepted every cycle
//   rd_addr     read address, sampled with rd_req
//   rd_valid    one-cycle response strobe
//   rd_data     response data, holds when rd_valid is low
//   rd_err      address decode error, qualified by rd_valid
//
// Address map:
//   0 .. NUM_CH-1  counter value, zero-extended
//   NUM_CH         overflow bitmap, bit i = overflow flag of channel i
//   above          rd_data = 0, rd_err = 1
// -----------------------------------------------------------------------------
module stat_counter_bank #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int ADDR_W   = 8,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] stat_valid,
  input  logic              stat_reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err
);

  // Read handshake: there is no ready signal. Every cycle with rd_req=1 is a
  // request that is accepted unconditionally; exactly one cycle later
  // rd_valid is high for one cycle with rd_data/rd_err for that address.
  // Responses never stall, so back-to-back requests give back-to-back
  // responses. While rd_valid is low, rd_data/rd_err keep their last value.

  localparam logic [CNT_W-1:0]  TERM_CNT    = '1;
  localparam logic [ADDR_W-1:0] BITMAP_ADDR = ADDR_W'(NUM_CH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  base  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;
  logic [NUM_CH-1:0] ovf_evt;

  // Read-side clear controls (all zero when clear-on-read is disabled).
  logic [NUM_CH-1:0] rd_clr;
  logic              bitmap_clr;

  // Read mux outputs, registered into the response.
  logic [CNT_W-1:0]  mux_data;
  logic              mux_err;

  // ---------------------------------------------------------------------------
  // Read-side clear decode
  // ---------------------------------------------------------------------------
`ifdef STAT_CLEAR_ON_READ_EN
  always_comb begin
    rd_clr     = '0;
    bitmap_clr = rd_req && (rd_addr == BITMAP_ADDR);
    for (int i = 0; i < NUM_CH; i++) begin
      rd_clr[i] = rd_req && (rd_addr == ADDR_W'(i));
    end
  end
`else
  always_comb begin
    rd_clr     = '0;
    bitmap_clr = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Counter next-state
  // ---------------------------------------------------------------------------
  // A clear-on-read zeroes the counter before the same-cycle event is
  // applied, so that event lands on the fresh counter (value becomes 1) and
  // cannot itself overflow. stat_reset overrides everything.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      base[i]    = rd_clr[i] ? '0 : cnt_q[i];
      ovf_evt[i] = stat_valid[i] && (base[i] == TERM_CNT);
      cnt_d[i]   = base[i];
      if (stat_valid[i]) begin
        if (base[i] == TERM_CNT) begin
          cnt_d[i] = (SATURATE != 0) ? TERM_CNT : '0;
        end else begin
          cnt_d[i] = base[i] + CNT_W'(1);
        end
      end
      // Overflow flags are sticky; a clearing read drops the old flag but
      // keeps any overflow that happens in the same cycle.
      ovf_d[i] = ((rd_clr[i] || bitmap_clr) ? 1'b0 : ovf_q[i]) | ovf_evt[i];
      if (stat_reset) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: uses the registered (pre-update) values of this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mux_data = '0;
    mux_err  = 1'b0;
    if (rd_addr > BITMAP_ADDR) begin
      mux_err = 1'b1;
    end else if (rd_addr == BITMAP_ADDR) begin
      mux_data = CNT_W'(ovf_q);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_addr == ADDR_W'(i)) begin
          mux_data = cnt_q[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= mux_data;
        rd_err  <= mux_err;
      end
    end
  end

endmodule

// File: doc/stat_counter_bank.md
Name: stat_counter_bank

Overview:
- Parametrised successor to the single-value statistics block: a bank of NUM_CH independent event counters with a memory-mapped read port.
- Each counter increments on its own stat_valid bit. stat_reset clears the whole bank.
- Software reads counters and a sticky overflow bitmap through a fixed-latency request/response port.
- Sits beside datapath blocks that emit per-event strobes.

Parameters:
- NUM_CH, 4, number of counter channels (1..CNT_W).
- CNT_W, 32, counter width in bits (2..64).
- ADDR_W, 8, read address width; must satisfy 2^ADDR_W > NUM_CH.
- SATURATE, 1, 1 = counter holds at all-ones; 0 = counter wraps to 0.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- stat_valid  input  NUM_CH  per-channel event strobe; bit i high = one event on channel i this cycle.
- stat_reset  input  1  synchronous bank clear (counters and overflow flags).
- rd_req  input  1  read request, one per cycle, always accepted.
- rd_addr  input  ADDR_W  read address, sampled when rd_req=1.
- rd_valid  output  1  response strobe.
- rd_data  output  CNT_W  response data.
- rd_err  output  1  address-decode error, qualified by rd_valid.

Behaviour:
- Reset (async assert, sync release): all counters 0, overflow flags 0, rd_valid 0, rd_data 0, rd_err 0.
- Counting: counter i increments by 1 in each cycle where stat_valid[i]=1.
- Counters are independent; all channels may increment in the same cycle.
- Terminal count = 2^CNT_W-1. An increment at terminal count sets ovf[i] (sticky).
  - SATURATE=1: counter stays at terminal count.
  - SATURATE=0: counter wraps to 0.
- stat_reset: next cycle all counters and ovf are 0. stat_reset wins over any same-cycle stat_valid; those events are dropped.
- Address map:
  - addr 0..NUM_CH-1: counter value, zero-extended to CNT_W.
  - addr NUM_CH: overflow bitmap, bit i = ovf[i], upper bits 0.
  - any higher addr: rd_data=0, rd_err=1.
- Read latency: exactly 1 cycle. rd_req in cycle N gives rd_valid=1 in cycle N+1 with data for addr.
- rd_valid is high for exactly one cycle per request. Back-to-back requests give back-to-back responses. No stall or backpressure.
- rd_data/rd_err hold their last value when rd_valid=0.
- Read coincident with an increment or stat_reset on the addressed channel: response returns the pre-update value (registered value at cycle N). The update still takes effect.
- Reset asserted mid-read: the response is discarded; rd_valid=0 while reset is high.

Optional Feature:
- Macro: STAT_CLEAR_ON_READ_EN.
- Defined: a successful counter read (addr < NUM_CH) clears that counter and its ovf bit after returning the old value.
  - A same-cycle increment on that channel is not lost; the counter becomes 1.
  - A read of addr NUM_CH returns the bitmap, then clears all ovf bits, except bits whose overflow occurs in that same cycle.
  - stat_reset still takes priority over both.
- Undefined: reads are non-destructive; only stat_reset and reset clear state.

Test Plan:
- Basic count: after reset, pulse stat_valid=4'b0101 for 10 cycles, then read addr 0,1,2,3 back-to-back -> rd_valid each following cycle, data 10,0,10,0, rd_err=0.
- Overflow: CNT_W=4, 17 events on channel 1.
  - SATURATE=1 -> addr 1 reads 15, addr 4 reads 0x2.
  - SATURATE=0 -> addr 1 reads 1, addr 4 reads 0x2.
- Bank clear collision: assert stat_reset together with stat_valid=4'b1111 and rd_req addr 2 (counter holding 7) -> response 7; next-cycle reads all 0, ovf bitmap 0.
- Bad address: rd_addr=5 and rd_addr=255 with NUM_CH=4 -> rd_valid=1, rd_data=0, rd_err=1; counters unchanged.
- Clear-on-read (macro defined): channel 0 at 5; read addr 0 while stat_valid[0]=1 -> returns 5; reread -> returns 1. Macro undefined -> second read returns 6.
- Async reset mid-operation: assert reset in the cycle after rd_req, between clock edges -> rd_valid, rd_data and all counters go 0 immediately; no response after release.
